// File: rtl/row_gen_pkg.sv
// rtl/row_gen_pkg.sv - shared constants and FSM state type for the matrix row generator
// Purpose: default matrix geometry, row counter width, LFSR feedback taps, FSM states.
// Ports: none (package).
package row_gen_pkg;

    localparam int NROWS_DEFAULT = 450;
    localparam int NCOLS_DEFAULT = 128;

    // Wide enough to count NROWS_DEFAULT rows.
    localparam int CNT_W = 9;

    // Galois feedback applied when the bit shifted out of the top is 1.
    localparam logic [7:0] LFSR_POLY = 8'h87;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/row_lfsr.sv
// rtl/row_lfsr.sv - Galois LFSR producing one matrix row per advance
// Purpose: holds the row generator state; loads a seed and steps on demand.
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   load_i, seed_i   load seed this cycle (an all-zero seed loads as 1)
//   adv_i            step the LFSR this cycle
//   row_o            registered current row (reads 0 out of reset)
module row_lfsr
    import row_gen_pkg::*;
#(
    parameter int W = NCOLS_DEFAULT
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    input  logic         adv_i,
    output logic [W-1:0] row_o
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;
    logic [W-1:0] row_q;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            // An all-zero state would lock up, so substitute 1.
            state_d = (seed_i == '0) ? W'(1) : seed_i;
        end else if (adv_i) begin
            state_d = {state_q[W-2:0], 1'b0} ^ (state_q[W-1] ? W'(LFSR_POLY) : '0);
        end
    end

    // row_q mirrors the state except out of reset, where the row reads as 0
    // while the generator itself restarts from 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= W'(1);
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= state_d;
        end
    end

    assign row_o = row_q;

endmodule

// File: rtl/row_gen.sv
// rtl/row_gen.sv - streams matrix A rows to a selection consumer for one challenge
// Purpose: on start, captures seed and row mask, pulses index_valid, then streams
//   LFSR rows under pause back-pressure until the consumer reports sel_done or all
//   NROWS rows are used (short_fail).
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   start, seed, index_in run request with seed and row-selection mask
//   pause, sel_done      consumer back-pressure and completion
//   index_valid, index_w mask load strobe and registered mask
//   en, row_input        row valid / consumer advance, current row
//   busy, finished, short_fail  run status
module row_gen
    import row_gen_pkg::*;
#(
    parameter int NROWS = NROWS_DEFAULT,
    parameter int NCOLS = NCOLS_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [NCOLS-1:0] seed,
    input  logic [NROWS-1:0] index_in,
    input  logic             pause,
    input  logic             sel_done,
    output logic             index_valid,
    output logic [NROWS-1:0] index_w,
    output logic             en,
    output logic [NCOLS-1:0] row_input,
    output logic             busy,
    output logic             finished,
    output logic             short_fail
);

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NROWS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NROWS-1:0] index_w_q, index_w_d;
    logic             short_fail_q, short_fail_d;
    logic             index_valid_q, index_valid_d;
    logic             busy_q, busy_d;
    logic             finished_q, finished_d;
    logic             capture;
    logic             en_c;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        index_w_d    = index_w_q;
        short_fail_d = short_fail_q;
        capture      = 1'b0;
        en_c         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    capture      = 1'b1;
                    index_w_d    = index_in;
                    short_fail_d = 1'b0;
                    cnt_d        = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                // sel_done wins over both pause and the last-row exit.
                if (sel_done) begin
                    state_d = ST_FLUSH;
                end else if (!pause) begin
                    en_c = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == LAST_ROW) begin
                        state_d      = ST_FLUSH;
                        short_fail_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe.
        index_valid_d = capture;
        busy_d        = (state_d != ST_IDLE);
        finished_d    = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            index_w_q     <= '0;
            short_fail_q  <= 1'b0;
            index_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            index_w_q     <= index_w_d;
            short_fail_q  <= short_fail_d;
            index_valid_q <= index_valid_d;
            busy_q        <= busy_d;
            finished_q    <= finished_d;
        end
    end

    row_lfsr #(
        .W(NCOLS)
    ) u_row_lfsr (
        .clk   (clk),
        .resetn(resetn),
        .load_i(capture),
        .seed_i(seed),
        .adv_i (en_c),
        .row_o (row_input)
    );

    assign en          = en_c;
    assign index_valid = index_valid_q;
    assign index_w     = index_w_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign short_fail  = short_fail_q;

endmodule

// File: doc/row_gen.md
ROW_GEN -- requirements
Module: row_gen

Interface
REQ-001 Parameter NROWS, default 450: rows of matrix A streamed per challenge.
REQ-002 Parameter NCOLS, default 128: row width in bits.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a run; ignored unless IDLE.
REQ-006 seed  input  NCOLS  LFSR seed for matrix A, sampled on accepted start.
REQ-007 index_in  input  NROWS  row-selection mask, sampled on accepted start; bit NROWS-1 is row 0.
REQ-008 pause  input  1  consumer back-pressure; high freezes streaming.
REQ-009 sel_done  input  1  consumer reports its selection count is reached.
REQ-010 index_valid  output  1  one-cycle strobe loading index_w into the consumer.
REQ-011 index_w  output  NROWS  registered copy of index_in.
REQ-012 en  output  1  row_input valid and the consumer's index advances this cycle.
REQ-013 row_input  output  NCOLS  current matrix A row.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 finished  output  1  one-cycle pulse when a run ends.
REQ-016 short_fail  output  1  high when a run exhausted NROWS rows without sel_done; held until next accepted start.

Function
REQ-017 FSM states: IDLE, LOAD, STREAM, FLUSH; encoding is free.
REQ-018 IDLE: start=1 -> LOAD next cycle; capture seed, index_in; clear short_fail and row counter.
REQ-019 LOAD: index_valid=1 for exactly this one cycle, en=0; -> STREAM.
REQ-020 STREAM: en = !pause; when en=1, row_input is row k, where k = number of prior en cycles this run (0-based).
REQ-021 Row k pairs with index_w bit NROWS-1-k; no gap cycles are inserted between LOAD and the first en other than pause.
REQ-022 LFSR: 128-bit Galois, next = (state<<1) XOR (state[127] ? 0x87 : 0); row_input = state; state advances only on en cycles.
REQ-023 Zero seed is replaced by 1 at capture.
REQ-024 Row counter 9 bits, increments on en; saturates and is never compared past NROWS-1.
REQ-025 sel_done=1 sampled in STREAM -> en=0 that cycle, -> FLUSH; takes priority over pause and over last-row condition.
REQ-026 en cycle with counter = NROWS-1 and sel_done=0 -> FLUSH, short_fail set next cycle.
REQ-027 FLUSH: en=0, finished=1 for one cycle, -> IDLE.
REQ-028 start while busy is ignored; no queuing.
REQ-029 All outputs registered except en, which is decoded from state, pause and sel_done.

Reset
REQ-030 resetn=0 at any time, including mid-STREAM: state IDLE, LFSR=1, counter=0, index_w=0, en=0, index_valid=0, busy=0, finished=0, short_fail=0, row_input=0.
REQ-031 Reset takes effect asynchronously; leaving reset needs no extra start delay, and the first start after reset is accepted.

Structure
REQ-032 The shared package holds NROWS, NCOLS, the LFSR feedback constant 0x87 and the FSM state type.
REQ-033 One sub-module, row_lfsr (seed load, advance enable, state output), is instantiated once; the FSM and counter stay in row_gen.

Verification
REQ-034 seed=1, pause=0, sel_done=0 -> rows 0..127 = 1<<k, row 128 = 0x87; 450 en cycles, then short_fail=1 and finished pulse.
REQ-035 start then sel_done asserted on the 200th en cycle -> exactly 199 rows emitted, en=0 from that cycle onward, finished one cycle later, short_fail=0.
REQ-036 pause high for 5 cycles after row 10 -> no en, row_input holds row 11 value, and the sequence resumes unchanged.
REQ-037 seed=0 -> row 0 = 1; index_in=all-ones -> index_w equals it and index_valid pulses once, in LOAD.
REQ-038 resetn low during row 300, then a new start -> outputs at reset values, row 0 of the new seed emitted first.
REQ-039 start pulses during STREAM -> no effect on the counter, LFSR or index_w.
